mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one sequential shift-add Multiplier instance among NUM_REQ independent requesters.
- Arbitration is round-robin. The block latches the winner's operands, pulses the multiplier's start, waits for productDone, and returns the product tagged with the requester id over a valid/ready response channel.
- Sits between the requester-side logic and a single Multiplier #(WIDTH) instance. Only one operation is in flight at a time.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 2*WIDTH+4, maximum cycles spent in WAIT before the operation is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until granted.
- req_ready  out  NUM_REQ  one-hot grant; handshake occurs when req_valid[i] && req_ready[i].
- req_multiplier  in  NUM_REQ*WIDTH  packed multipliers; requester i at [i*WIDTH +: WIDTH].
- req_multiplicand  in  NUM_REQ*WIDTH  packed multiplicands; same packing.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_product  out  2*WIDTH  product, or 0 on error.
- resp_error  out  1  operation timed out.
- busy  out  1  high in any state other than IDLE.
- mult_start  out  1  to Multiplier.start; one-cycle pulse.
- mult_multiplier  out  WIDTH  to Multiplier.multiplier; registered, stable from ISSUE until return to IDLE.
- mult_multiplicand  out  WIDTH  to Multiplier.multiplicand; same timing.
- mult_product  in  2*WIDTH  from Multiplier.product.
- mult_done  in  1  from Multiplier.productDone.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, and all outputs and registers 0. The Multiplier shares rst, so a reset mid-operation aborts it. No response is produced for an aborted operation.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant search runs combinationally from rr_ptr upward, wrapping at NUM_REQ-1 to 0. The first i with req_valid[i]=1 wins.
  - req_ready is asserted only for that i, and only in IDLE.
  - On handshake: latch operands into mult_multiplier/mult_multiplicand, latch id i, then go to ISSUE.
  - With no request pending: stay in IDLE with req_ready=0.
- ISSUE: mult_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - mult_done is ignored in the first WAIT cycle, which masks a stale done from the previous operation.
  - From the second WAIT cycle on, mult_done=1 registers mult_product into resp_product, sets resp_error=0, and moves to RESP.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT with no done: resp_product=0, resp_error=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - resp_valid=1. resp_id, resp_product and resp_error are held stable until resp_ready=1.
  - On handshake: rr_ptr = latched id + 1, wrapping to 0 after NUM_REQ-1. Then go to IDLE.
  - New requests are not granted in RESP. Back-pressure on resp_ready stalls arbitration indefinitely.
- Latency: handshake in cycle T → mult_start in T+1 → done accepted no earlier than T+3 → resp_valid in the cycle after done is seen. Minimum request-to-response is 3 cycles plus the Multiplier latency.
- Fairness: a continuously requesting requester is granted within NUM_REQ arbitrations.
- Requests dropped before grant are never serviced. A requester deasserting req_valid while not granted is legal.
- Arithmetic: the product is unsigned WIDTH x WIDTH → 2*WIDTH, taken directly from the Multiplier with no truncation.
- The block never asserts mult_start outside ISSUE. Back-to-back operations are separated by at least the RESP and IDLE cycles.

Test Plan (WIDTH=4, NUM_REQ=4):
- Single request: req 2 with 7×9 → one grant to req_ready[2], one mult_start pulse; response id=2, product=63, error=0, busy low after resp handshake.
- All four valid continuously with operands 15×15, 3×5, 0×12, 1×1 → grants in order 0,1,2,3,0; products 225, 15, 0, 1, 225.
- Response back-pressure: resp_ready=0 for 10 cycles → resp_valid and data held, req_ready stays 0 throughout; completes after resp_ready=1.
- Timeout: mult_done tied 0 → resp_error=1, resp_product=0 exactly TIMEOUT WAIT cycles after ISSUE; next requester is then served normally.
- Stale done: mult_done held 1 entering WAIT with a new product arriving later → the first WAIT cycle is ignored, and the captured value is the new operation's product.
- Reset mid-WAIT: assert rst → all outputs 0 immediately, state IDLE, rr_ptr=0; the next request from req 1 is served with the correct product.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential shift-add multiplier among
// NUM_REQ requesters. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/ready     per-requester request and one-hot grant (IDLE only)
//   req_multiplier/     packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_multiplicand
//   resp_valid/ready    response handshake
//   resp_id             requester that owns the response
//   resp_product        product, or 0 when the operation timed out
//   resp_error          operation timed out
//   busy                high in any state other than IDLE
//   mult_start          one-cycle start pulse to the multiplier
//   mult_multiplier/    registered operands to the multiplier
//   mult_multiplicand
//   mult_product/done   result and completion flag from the multiplier
module mult_share_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,  // 2**ID_W must cover NUM_REQ
  parameter int unsigned TIMEOUT = 2 * WIDTH + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     resp_error,
  output logic                     busy,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_multiplier,
  output logic [WIDTH-1:0]         mult_multiplicand,
  input  logic [2*WIDTH-1:0]       mult_product,
  input  logic                     mult_done
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e              r_state, w_state_next;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_next;
  logic [ID_W-1:0]     r_id, w_id_next;
  logic [WIDTH-1:0]    r_op_a, w_op_a_next;
  logic [WIDTH-1:0]    r_op_b, w_op_b_next;
  logic [CntW-1:0]     r_cnt, w_cnt_next;
  logic [2*WIDTH-1:0]  r_product, w_product_next;
  logic                r_error, w_error_next;

  // Grant search
  logic                w_hi_found, w_lo_found, w_grant_valid;
  logic [ID_W-1:0]     w_hi_idx, w_lo_idx, w_grant_idx;
  logic [WIDTH-1:0]    w_sel_a, w_sel_b;

  // Two priority passes: lowest valid index at or above rr_ptr, else lowest
  // valid index overall. Together this is a search from rr_ptr with wrap.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = ID_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
    w_grant_valid = w_lo_found;
    w_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    req_ready = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a = req_multiplier[i*WIDTH +: WIDTH];
        w_sel_b = req_multiplicand[i*WIDTH +: WIDTH];
        // Gated by rst so every output reads 0 while reset is held.
        req_ready[i] = (r_state == StIdle) && w_grant_valid && !rst;
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    w_state_next   = r_state;
    w_rr_ptr_next  = r_rr_ptr;
    w_id_next      = r_id;
    w_op_a_next    = r_op_a;
    w_op_b_next    = r_op_b;
    w_cnt_next     = r_cnt;
    w_product_next = r_product;
    w_error_next   = r_error;

    unique case (r_state)
      StIdle: begin
        if (w_grant_valid) begin
          w_op_a_next  = w_sel_a;
          w_op_b_next  = w_sel_b;
          w_id_next    = w_grant_idx;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_cnt_next   = '0;
        w_state_next = StWait;
      end
      StWait: begin
        w_cnt_next = r_cnt + CntW'(1);
        // r_cnt == 0 marks the first WAIT cycle, where done may still be
        // left over from the previous operation. Done beats timeout.
        if (mult_done && (r_cnt != '0)) begin
          w_product_next = mult_product;
          w_error_next   = 1'b0;
          w_state_next   = StResp;
        end else if ((r_cnt + CntW'(1)) == TimeoutCnt) begin
          w_product_next = '0;
          w_error_next   = 1'b1;
          w_state_next   = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          w_rr_ptr_next = (r_id == LastId) ? '0 : r_id + ID_W'(1);
          w_state_next  = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_id      <= w_id_next;
      r_op_a    <= w_op_a_next;
      r_op_b    <= w_op_b_next;
      r_cnt     <= w_cnt_next;
      r_product <= w_product_next;
      r_error   <= w_error_next;
    end
  end

  assign mult_start        = (r_state == StIssue);
  assign resp_valid        = (r_state == StResp);
  assign busy              = (r_state != StIdle);
  assign resp_id           = r_id;
  assign resp_product      = r_product;
  assign resp_error        = r_error;
  assign mult_multiplier   = r_op_a;
  assign mult_multiplicand = r_op_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier peer.
module tb_mult_share_arbiter;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 2 * WIDTH + 4;
  localparam int LAT     = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_multiplier = '0;
  logic [NUM_REQ*WIDTH-1:0] req_multiplicand = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b0;
  logic [ID_W-1:0]          resp_id;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     resp_error;
  logic                     busy;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_multiplier;
  logic [WIDTH-1:0]         mult_multiplicand;
  logic [2*WIDTH-1:0]       mult_product;
  logic                     mult_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .WIDTH  (WIDTH),
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_id          (resp_id),
    .resp_product     (resp_product),
    .resp_error       (resp_error),
    .busy             (busy),
    .mult_start       (mult_start),
    .mult_multiplier  (mult_multiplier),
    .mult_multiplicand(mult_multiplicand),
    .mult_product     (mult_product),
    .mult_done        (mult_done)
  );

  // Multiplier peer. Mode 0: done pulses LAT cycles after start.
  // Mode 1: done never rises. Mode 2: done is held high after completion and
  // stays high through the first WAIT cycle of the next operation.
  int               m_mode = 0;
  int               m_cnt;
  logic             m_busy, m_stale_clr;
  logic [WIDTH-1:0] m_a, m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_done    <= 1'b0;
      mult_product <= '0;
      m_busy       <= 1'b0;
      m_stale_clr  <= 1'b0;
      m_cnt        <= 0;
      m_a          <= '0;
      m_b          <= '0;
    end else if (mult_start) begin
      m_busy <= 1'b1;
      m_cnt  <= LAT;
      m_a    <= mult_multiplier;
      m_b    <= mult_multiplicand;
      if (m_mode == 2) m_stale_clr <= 1'b1;
      else mult_done <= 1'b0;
    end else begin
      if (m_stale_clr) begin
        mult_done   <= 1'b0;
        m_stale_clr <= 1'b0;
      end else if (m_mode != 2) begin
        mult_done <= 1'b0;
      end
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          if (m_mode != 1) begin
            mult_done    <= 1'b1;
            mult_product <= m_a * m_b;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic apply_reset();
    req_valid  = '0;
    resp_ready = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_op(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_multiplier[idx*WIDTH +: WIDTH]   = a;
    req_multiplicand[idx*WIDTH +: WIDTH] = b;
  endtask

  // Raise req idx, wait for a grant, then wait (bounded) for resp_valid.
  // Returns at the negedge where resp_valid was first seen.
  task automatic run_op(input int idx, input bit drop, output logic [NUM_REQ-1:0] grant,
                        output bit got_resp);
    req_valid[idx] = 1'b1;
    grant = '0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready != '0) begin
        grant = req_ready;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (drop) req_valid[idx] = 1'b0;
    got_resp = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (resp_valid) begin
        got_resp = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start,
         mult_multiplier, mult_multiplicand} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d p=%0d e=%b busy=%b st=%b a=%0d b=%0d want all 0",
               req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start,
               mult_multiplier, mult_multiplicand);
    end
    apply_reset();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    int starts;
    int cyc;
    apply_reset();
    m_mode = 0;
    set_op(2, 4'd7, 4'd9);
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    n_vec++;
    if ({mult_start, busy, mult_multiplier, mult_multiplicand, req_ready} !==
        {1'b1, 1'b1, 4'd7, 4'd9, 4'b0000}) begin
      n_err++;
      $display("FAIL single_issue: got st=%b busy=%b a=%0d b=%0d rdy=%b want 1 1 7 9 0000",
               mult_start, busy, mult_multiplier, mult_multiplicand, req_ready);
    end
    starts = 0;
    cyc = 0;
    @(negedge clk);
    while (!resp_valid && cyc < 50) begin
      if (mult_start) starts++;
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc !== 5 || starts !== 0) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles %0d extra starts want 5 and 0", cyc, starts);
    end
    n_vec++;
    if ({resp_valid, resp_id, resp_product, resp_error} !== {1'b1, 2'd2, 8'd63, 1'b0}) begin
      n_err++;
      $display("FAIL single_resp: got v=%b id=%0d p=%0d e=%b want 1 2 63 0",
               resp_valid, resp_id, resp_product, resp_error);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_vec++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL single_done_idle: got v=%b busy=%b want 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int                 exp_id[5]   = '{0, 1, 2, 3, 0};
    int                 exp_prod[5] = '{225, 15, 0, 1, 225};
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    apply_reset();
    m_mode = 0;
    set_op(0, 4'd15, 4'd15);
    set_op(1, 4'd3, 4'd5);
    set_op(2, 4'd0, 4'd12);
    set_op(3, 4'd1, 4'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_op(exp_id[k], 1'b0, g, ok);
      n_vec++;
      if (g !== NUM_REQ'(1 << exp_id[k])) begin
        n_err++;
        $display("FAIL rr_grant%0d: got %b want id %0d", k, g, exp_id[k]);
      end
      n_vec++;
      if ({ok, resp_id, resp_product, resp_error} !==
          {1'b1, ID_W'(exp_id[k]), 8'(exp_prod[k]), 1'b0}) begin
        n_err++;
        $display("FAIL rr_resp%0d: got v=%b id=%0d p=%0d e=%b want 1 %0d %0d 0",
                 k, ok, resp_id, resp_product, resp_error, exp_id[k], exp_prod[k]);
      end
      finish_resp();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    apply_reset();
    m_mode = 0;
    set_op(1, 4'd5, 4'd6);
    set_op(0, 4'd2, 4'd2);
    set_op(2, 4'd3, 4'd3);
    run_op(1, 1'b1, g, ok);
    req_valid = 4'b0101;
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL bp_resp_seen: got %b want 1", ok);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++;
      if ({resp_valid, resp_id, resp_product, resp_error, req_ready} !==
          {1'b1, 2'd1, 8'd30, 1'b0, 4'b0000}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d p=%0d e=%b rdy=%b want 1 1 30 0 0000",
                 k, resp_valid, resp_id, resp_product, resp_error, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    // Pointer now sits just past requester 1, so requester 2 wins over 0.
    n_vec++;
    if ({busy, resp_valid, req_ready} !== {1'b0, 1'b0, 4'b0100}) begin
      n_err++;
      $display("FAIL bp_release: got busy=%b v=%b rdy=%b want 0 0 0100", busy, resp_valid, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    int                 cyc;
    apply_reset();
    m_mode = 1;
    set_op(3, 4'd2, 4'd3);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    n_vec++;
    if (mult_start !== 1'b1) begin
      n_err++;
      $display("FAIL to_issue: got start=%b want 1", mult_start);
    end
    cyc = 0;
    @(negedge clk);
    while (!resp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc !== TIMEOUT) begin
      n_err++;
      $display("FAIL to_latency: got %0d WAIT-to-RESP cycles want %0d", cyc, TIMEOUT);
    end
    n_vec++;
    if ({resp_valid, resp_id, resp_product, resp_error} !== {1'b1, 2'd3, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL to_resp: got v=%b id=%0d p=%0d e=%b want 1 3 0 1",
               resp_valid, resp_id, resp_product, resp_error);
    end
    finish_resp();
    m_mode = 0;
    set_op(0, 4'd4, 4'd4);
    run_op(0, 1'b1, g, ok);
    n_vec++;
    if ({g, ok, resp_id, resp_product, resp_error} !== {4'b0001, 1'b1, 2'd0, 8'd16, 1'b0}) begin
      n_err++;
      $display("FAIL to_next: got g=%b v=%b id=%0d p=%0d e=%b want 0001 1 0 16 0",
               g, ok, resp_id, resp_product, resp_error);
    end
    finish_resp();
  endtask

  task automatic test_stale_done();
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    apply_reset();
    m_mode = 2;
    set_op(0, 4'd13, 4'd11);
    run_op(0, 1'b1, g, ok);
    n_vec++;
    if ({ok, resp_id, resp_product, resp_error} !== {1'b1, 2'd0, 8'd143, 1'b0}) begin
      n_err++;
      $display("FAIL stale_first: got v=%b id=%0d p=%0d e=%b want 1 0 143 0",
               ok, resp_id, resp_product, resp_error);
    end
    finish_resp();
    set_op(1, 4'd6, 4'd7);
    run_op(1, 1'b1, g, ok);
    n_vec++;
    if ({ok, resp_id, resp_product, resp_error} !== {1'b1, 2'd1, 8'd42, 1'b0}) begin
      n_err++;
      $display("FAIL stale_second: got v=%b id=%0d p=%0d e=%b want 1 1 42 0",
               ok, resp_id, resp_product, resp_error);
    end
    finish_resp();
    m_mode = 0;
  endtask

  task automatic test_reset_mid_wait();
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    apply_reset();
    m_mode = 0;
    set_op(2, 4'd9, 4'd2);
    run_op(2, 1'b1, g, ok);
    n_vec++;
    if ({ok, resp_id, resp_product} !== {1'b1, 2'd2, 8'd18}) begin
      n_err++;
      $display("FAIL rmw_pre: got v=%b id=%0d p=%0d want 1 2 18", ok, resp_id, resp_product);
    end
    finish_resp();
    set_op(3, 4'd9, 4'd9);
    set_op(1, 4'd3, 4'd7);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, resp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rmw_in_wait: got busy=%b v=%b want 1 0", busy, resp_valid);
    end
    req_valid = 4'b1010;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start,
         mult_multiplier, mult_multiplicand} !== '0) begin
      n_err++;
      $display("FAIL rmw_async_clear: got rdy=%b v=%b id=%0d p=%0d e=%b busy=%b st=%b a=%0d b=%0d want all 0",
               req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start,
               mult_multiplier, mult_multiplicand);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0010;
    run_op(1, 1'b1, g, ok);
    n_vec++;
    if ({g, ok, resp_id, resp_product, resp_error} !== {4'b0010, 1'b1, 2'd1, 8'd21, 1'b0}) begin
      n_err++;
      $display("FAIL rmw_after: got g=%b v=%b id=%0d p=%0d e=%b want 0010 1 1 21 0",
               g, ok, resp_id, resp_product, resp_error);
    end
    finish_resp();
  endtask

  // With requesters 1 and 3 both pending after reset, the pointer must be
  // back at 0 so requester 1 is chosen.
  task automatic test_ptr_after_reset();
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    apply_reset();
    set_op(2, 4'd1, 4'd2);
    run_op(2, 1'b1, g, ok);
    finish_resp();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL ptr_reset: got %b want 0010", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_reset_mid_wait();
    test_ptr_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
